timer_irq_aggregator: RTL and testbench
=======================================

TIMER_IRQ_AGGREGATOR -- requirements
Module: timer_irq_aggregator

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: PCLK  input  1  sole clock, all state on rising edge; PRESET  input  1  synchronous active-high reset.
REQ-002 SHALL have APB3 slave inputs: PSEL  input  1  select; PADDR  input  [11:2]  word address; PENABLE  input  1  access phase; PWRITE  input  1  write; PWDATA  input  32  write data.
REQ-003 SHALL have APB3 slave outputs: PRDATA  output  32  read data; PREADY  output  1  ready; PSLVERR  output  1  error.
REQ-004 SHALL have event and interrupt ports: TIMERINT  input  [1:0]  level interrupts from timer0/timer1; IRQ  output  1  combined registered interrupt.

Function
REQ-005 SHALL define transfers: access = PSEL & PENABLE; write = access & PWRITE; read = access & ~PWRITE; no wait states, PREADY tied 1.
REQ-006 SHALL map registers (byte offset): 0x000 RAWPEND RO [1:0]; 0x004 ENABLE RW [1:0]; 0x008 CLEAR WO; 0x00C MASKPEND RO [1:0] = RAWPEND & ENABLE; 0x010 COUNT0 RO [15:0]; 0x014 COUNT1 RO [15:0]; unused bits read 0.
REQ-007 SHALL drive PSLVERR=1 for an access to offsets above 0x014, for writes to RO registers, and for reads of CLEAR; any such write SHALL change no state; PSLVERR=0 otherwise and when no access is in progress.
REQ-008 SHALL drive PRDATA with the selected register value during a read access and 0 otherwise, including for erroring accesses.
REQ-009 SHALL register TIMERINT[n] into tint_q[n] every cycle; a rising edge SHALL be detected when TIMERINT[n]=1 and tint_q[n]=0.
REQ-010 SHALL set RAWPEND[n] on the clock edge at which a rising edge of TIMERINT[n] is detected; a level held high SHALL NOT re-set pending after it is cleared.
REQ-011 SHALL clear RAWPEND[n] when CLEAR is written with PWDATA[n]=1; if a set and a clear of the same bit occur in one cycle, set SHALL win.
REQ-012 SHALL increment COUNTn by 1 on each detected rising edge of TIMERINT[n], saturating at 0xFFFF with no wrap.
REQ-013 SHALL reset COUNTn to 0 when CLEAR is written with PWDATA[8+n]=1; on a simultaneous edge and counter clear, COUNTn SHALL become 1.
REQ-014 SHALL register IRQ = |(RAWPEND & ENABLE), so IRQ rises 2 cycles after TIMERINT rises when enabled and falls 1 cycle after the clearing write or ENABLE clear.
REQ-015 SHALL make an ENABLE write take effect on the following edge and SHALL NOT alter RAWPEND, so pending events latched while disabled assert IRQ once enabled.

Reset
REQ-016 SHALL clear on PRESET=1: tint_q=0, RAWPEND=0, ENABLE=0, COUNT0=COUNT1=0, IRQ=0; PRDATA=0 and PSLVERR=0 while PRESET is high.
REQ-017 SHALL, after reset release, treat TIMERINT already high as a rising edge in the first cycle (tint_q=0).
REQ-018 SHALL let PRESET override any in-flight APB write or edge event in the same cycle.

Configuration
REQ-019 SHALL compile COUNT0/COUNT1 and their clear logic only when macro TIMER_IRQ_AGG_COUNT_EN is defined; without it, 0x010/0x014 SHALL read 0 with PSLVERR=0, CLEAR bits [9:8] SHALL be ignored, and no counter flops SHALL exist.

Verification
REQ-020 SHALL cover: write ENABLE=0x3, pulse TIMERINT[0] high 1 cycle -> RAWPEND=0x1, IRQ=1 exactly 2 cycles after rise, COUNT0=1.
REQ-021 SHALL cover: TIMERINT[1] held high 10 cycles with ENABLE=0 -> RAWPEND=0x2, IRQ=0, COUNT1=1; then write ENABLE=0x2 -> IRQ=1 2 cycles after the write.
REQ-022 SHALL cover: CLEAR write 0x1 in the same cycle as a TIMERINT[0] rising edge -> RAWPEND[0] stays 1, IRQ stays 1.
REQ-023 SHALL cover: 70000 TIMERINT[0] pulses -> COUNT0=0xFFFF; then CLEAR write 0x100 -> COUNT0=0 (with TIMER_IRQ_AGG_COUNT_EN defined).
REQ-024 SHALL cover: read offset 0x018 and write offset 0x000 -> PSLVERR=1, PRDATA=0, RAWPEND unchanged.
REQ-025 SHALL cover: PRESET asserted mid-write to ENABLE with RAWPEND=0x3 -> all registers 0, IRQ=0 on the next edge.

Source files
------------

// File: rtl/timer_irq_aggregator_if.sv
// APB3 slave bus bundle for timer_irq_aggregator.
// The master modport is the bus side that drives requests; the slave modport is the aggregator.
interface timer_irq_aggregator_if;
   logic        PSEL;
   logic [11:2] PADDR;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/timer_irq_aggregator.sv
// timer_irq_aggregator: latches rising edges of two timer interrupt levels into
// pending bits, masks them with an enable register and drives one registered IRQ.
// Optional per-timer 16-bit saturating edge counters are built only when the
// macro TIMER_IRQ_AGG_COUNT_EN is defined; otherwise their addresses read as 0.
// Register map (byte offset): 0x000 RAWPEND, 0x004 ENABLE, 0x008 CLEAR,
// 0x00C MASKPEND, 0x010 COUNT0, 0x014 COUNT1.
module timer_irq_aggregator (
   input  logic                         PCLK,
   input  logic                         PRESET,
   timer_irq_aggregator_if.slave        apb,
   input  logic [1:0]                   TIMERINT,
   output logic                         IRQ
);

   localparam logic [9:0] IDX_RAWPEND  = 10'd0;
   localparam logic [9:0] IDX_ENABLE   = 10'd1;
   localparam logic [9:0] IDX_CLEAR    = 10'd2;
   localparam logic [9:0] IDX_MASKPEND = 10'd3;
   localparam logic [9:0] IDX_COUNT0   = 10'd4;
   localparam logic [9:0] IDX_COUNT1   = 10'd5;

   logic        access_s;
   logic        wr_s;
   logic        rd_s;
   logic        hit_s;
   logic        ro_s;
   logic        wo_s;
   logic        err_s;
   logic [31:0] reg_val_s;
   logic        enable_wr_s;
   logic        clear_wr_s;
   logic [1:0]  clr_mask_s;
   logic [1:0]  rise_s;

   logic [1:0]  tint_q_r;
   logic [1:0]  rawpend_r;
   logic [1:0]  enable_r;
   logic        irq_r;

`ifdef TIMER_IRQ_AGG_COUNT_EN
   logic [1:0][15:0] count_r;
`endif

   // Transfer qualification and edge detection.
   always_comb begin
      access_s = apb.PSEL & apb.PENABLE;
      wr_s     = access_s & apb.PWRITE;
      rd_s     = access_s & ~apb.PWRITE;
      rise_s   = TIMERINT & ~tint_q_r;
   end

   // Address decode: register value, access attributes and error flag.
   always_comb begin
      reg_val_s = 32'd0;
      hit_s     = 1'b1;
      ro_s      = 1'b0;
      wo_s      = 1'b0;
      case (apb.PADDR)
         IDX_RAWPEND: begin
            reg_val_s = {30'd0, rawpend_r};
            ro_s      = 1'b1;
         end
         IDX_ENABLE: begin
            reg_val_s = {30'd0, enable_r};
         end
         IDX_CLEAR: begin
            wo_s      = 1'b1;
         end
         IDX_MASKPEND: begin
            reg_val_s = {30'd0, rawpend_r & enable_r};
            ro_s      = 1'b1;
         end
         IDX_COUNT0: begin
`ifdef TIMER_IRQ_AGG_COUNT_EN
            reg_val_s = {16'd0, count_r[0]};
`else
            reg_val_s = 32'd0;
`endif
            ro_s      = 1'b1;
         end
         IDX_COUNT1: begin
`ifdef TIMER_IRQ_AGG_COUNT_EN
            reg_val_s = {16'd0, count_r[1]};
`else
            reg_val_s = 32'd0;
`endif
            ro_s      = 1'b1;
         end
         default: begin
            hit_s     = 1'b0;
         end
      endcase
      err_s       = access_s & (~hit_s | (apb.PWRITE & ro_s) | (~apb.PWRITE & wo_s));
      enable_wr_s = wr_s & ~err_s & (apb.PADDR == IDX_ENABLE);
      clear_wr_s  = wr_s & ~err_s & (apb.PADDR == IDX_CLEAR);
      if (clear_wr_s) begin
         clr_mask_s = apb.PWDATA[1:0];
      end else begin
         clr_mask_s = 2'b00;
      end
   end

   // APB response: zero-wait, data only for a good read, everything quiet in reset.
   always_comb begin
      apb.PREADY = 1'b1;
      if (PRESET) begin
         apb.PRDATA  = 32'd0;
         apb.PSLVERR = 1'b0;
      end else if (rd_s && !err_s) begin
         apb.PRDATA  = reg_val_s;
         apb.PSLVERR = 1'b0;
      end else begin
         apb.PRDATA  = 32'd0;
         apb.PSLVERR = err_s;
      end
   end

   // Edge history, pending bits (set beats clear), enable and registered IRQ.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tint_q_r  <= 2'b00;
         rawpend_r <= 2'b00;
         enable_r  <= 2'b00;
         irq_r     <= 1'b0;
      end else begin
         tint_q_r  <= TIMERINT;
         rawpend_r <= (rawpend_r & ~clr_mask_s) | rise_s;
         if (enable_wr_s) begin
            enable_r <= apb.PWDATA[1:0];
         end else begin
            enable_r <= enable_r;
         end
         irq_r     <= |(rawpend_r & enable_r);
      end
   end

`ifdef TIMER_IRQ_AGG_COUNT_EN
   // Saturating edge counters; a clear coinciding with an edge leaves a count of one.
   always_ff @(posedge PCLK) begin
      for (int n = 0; n < 2; n++) begin
         if (PRESET) begin
            count_r[n] <= 16'd0;
         end else if (clear_wr_s && apb.PWDATA[8+n]) begin
            count_r[n] <= rise_s[n] ? 16'd1 : 16'd0;
         end else if (rise_s[n] && (count_r[n] != 16'hFFFF)) begin
            count_r[n] <= count_r[n] + 16'd1;
         end else begin
            count_r[n] <= count_r[n];
         end
      end
   end

   logic unused_s;
   assign unused_s = ^{apb.PWDATA[31:10], apb.PWDATA[7:2]};
`else
   logic unused_s;
   assign unused_s = ^{apb.PWDATA[31:8], apb.PWDATA[7:2]};
`endif

   assign IRQ = irq_r;

endmodule

// File: tb/tb_timer_irq_aggregator.sv
// Self-checking bench for timer_irq_aggregator: register-access vector table,
// directed multi-cycle sequences and a randomized run against a reference model.
// Counter expectations follow TIMER_IRQ_AGG_COUNT_EN when it is defined.
module tb_timer_irq_aggregator;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic [1:0] TIMERINT;
   logic       IRQ;

   timer_irq_aggregator_if bus ();

   timer_irq_aggregator dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .apb      (bus),
      .TIMERINT (TIMERINT),
      .IRQ      (IRQ)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit [1:0] m_pend;
   bit [1:0] m_en;
   bit [1:0] m_prev;
   int       m_cnt [2];
   bit       m_irq;

   logic [31:0] last_rdata;
   logic        last_err;

`ifdef TIMER_IRQ_AGG_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] m_reg(input int idx);
      case (idx)
         0:       return {30'd0, m_pend};
         1:       return {30'd0, m_en};
         3:       return {30'd0, m_pend & m_en};
         4:       return CNT_ON ? m_cnt[0] : 32'd0;
         5:       return CNT_ON ? m_cnt[1] : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit m_err(input bit acc, input bit wr, input int idx);
      if (!acc) return 1'b0;
      if (idx > 5) return 1'b1;
      if (wr && (idx == 0 || idx >= 3)) return 1'b1;
      if (!wr && idx == 2) return 1'b1;
      return 1'b0;
   endfunction

   // advance the model across one rising clock edge using the current inputs
   task automatic model_step();
      bit acc;
      int idx;
      bit err;
      bit clr_wr;
      acc = bus.PSEL && bus.PENABLE;
      idx = int'(bus.PADDR);
      err = m_err(acc, bus.PWRITE, idx);
      if (PRESET) begin
         m_pend = 2'b00; m_en = 2'b00; m_prev = 2'b00; m_irq = 1'b0;
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         m_irq  = (m_pend & m_en) != 2'b00;
         clr_wr = acc && bus.PWRITE && !err && idx == 2;
         for (int n = 0; n < 2; n++) begin
            bit rise;
            rise = TIMERINT[n] && !m_prev[n];
            if (rise) m_pend[n] = 1'b1;
            else if (clr_wr && bus.PWDATA[n]) m_pend[n] = 1'b0;
            if (clr_wr && bus.PWDATA[8+n]) m_cnt[n] = rise ? 1 : 0;
            else if (rise && m_cnt[n] < 65535) m_cnt[n] = m_cnt[n] + 1;
         end
         if (acc && bus.PWRITE && !err && idx == 1) m_en = bus.PWDATA[1:0];
         m_prev = TIMERINT;
      end
   endtask

   // one clock: compare outputs mid-cycle, then step the model at the edge
   task automatic tick();
      bit acc;
      bit err;
      logic [31:0] exp_rd;
      @(negedge PCLK);
      acc    = bus.PSEL && bus.PENABLE;
      err    = PRESET ? 1'b0 : m_err(acc, bus.PWRITE, int'(bus.PADDR));
      exp_rd = (!PRESET && acc && !bus.PWRITE && !err) ? m_reg(int'(bus.PADDR)) : 32'd0;
      check("irq", {31'd0, IRQ}, {31'd0, m_irq});
      check("pslverr", {31'd0, bus.PSLVERR}, {31'd0, err});
      check("prdata", bus.PRDATA, exp_rd);
      check("pready", {31'd0, bus.PREADY}, 32'd1);
      last_rdata = bus.PRDATA;
      last_err   = bus.PSLVERR;
      @(posedge PCLK);
      model_step();
      #1;
   endtask

   task automatic idle();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_xfer(input bit wr, input logic [11:0] off, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
      bus.PADDR = off[11:2]; bus.PWDATA = wd;
      tick();
      bus.PENABLE = 1'b1;
      tick();
      rd = last_rdata; err = last_err;
      idle();
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      tick(); tick();
      PRESET = 1'b0;
   endtask

   typedef struct {
      bit          wr;
      logic [11:0] off;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic [31:0] rd;
      logic        er;

      vecs[0]  = '{1'b1, 12'h004, 32'h0000_0003, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 12'h004, 32'h0,         32'h3, 1'b0};
      vecs[2]  = '{1'b0, 12'h000, 32'h0,         32'h0, 1'b0};
      vecs[3]  = '{1'b1, 12'h000, 32'h0000_0001, 32'h0, 1'b1};
      vecs[4]  = '{1'b0, 12'h008, 32'h0,         32'h0, 1'b1};
      vecs[5]  = '{1'b0, 12'h018, 32'h0,         32'h0, 1'b1};
      vecs[6]  = '{1'b1, 12'h018, 32'h0000_0003, 32'h0, 1'b1};
      vecs[7]  = '{1'b0, 12'hFFC, 32'h0,         32'h0, 1'b1};
      vecs[8]  = '{1'b1, 12'h004, 32'hFFFF_FFFE, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 12'h004, 32'h0,         32'h2, 1'b0};
      vecs[10] = '{1'b0, 12'h00C, 32'h0,         32'h0, 1'b0};
      vecs[11] = '{1'b0, 12'h010, 32'h0,         32'h0, 1'b0};
      vecs[12] = '{1'b1, 12'h00C, 32'h0000_0001, 32'h0, 1'b1};
      vecs[13] = '{1'b1, 12'h010, 32'h0000_0001, 32'h0, 1'b1};
      vecs[14] = '{1'b0, 12'h014, 32'h0,         32'h0, 1'b0};
      vecs[15] = '{1'b1, 12'h008, 32'h0000_0303, 32'h0, 1'b0};
      vecs[16] = '{1'b0, 12'h004, 32'h0,         32'h2, 1'b0};

      m_pend = 2'b00; m_en = 2'b00; m_prev = 2'b00; m_irq = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      PRESET = 1'b1; TIMERINT = 2'b00;
      bus.PADDR = 10'd0; bus.PWDATA = 32'd0;
      idle();
      do_reset();
      check("reset_irq", {31'd0, IRQ}, 32'd0);
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("reset_rawpend", rd, 32'h0);
      apb_xfer(1'b0, 12'h004, 32'h0, rd, er);
      check("reset_enable", rd, 32'h0);

      // register access table
      for (int i = 0; i < 17; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].off, vecs[i].wdata, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      end

      // single pulse on timer0 with both enabled
      do_reset();
      apb_xfer(1'b1, 12'h004, 32'h3, rd, er);
      TIMERINT = 2'b01;
      tick();
      check("pulse_irq_not_early", {31'd0, IRQ}, 32'd0);
      TIMERINT = 2'b00;
      tick();
      check("pulse_irq_2cyc", {31'd0, IRQ}, 32'd1);
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("pulse_rawpend", rd, 32'h1);
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("pulse_count0", rd, CNT_ON ? 32'd1 : 32'd0);

      // clear racing a new edge: set wins
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 10'd2; bus.PWDATA = 32'h1;
      tick();
      bus.PENABLE = 1'b1; TIMERINT = 2'b01;
      tick();
      idle(); TIMERINT = 2'b00;
      check("race_irq_a", {31'd0, IRQ}, 32'd1);
      tick();
      check("race_irq_b", {31'd0, IRQ}, 32'd1);
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("race_rawpend", rd, 32'h1);
      apb_xfer(1'b1, 12'h008, 32'h1, rd, er);
      check("clr_irq_lag", {31'd0, IRQ}, 32'd1);
      tick();
      check("clr_irq_fall", {31'd0, IRQ}, 32'd0);

      // held level while disabled, then enable
      do_reset();
      TIMERINT = 2'b10;
      for (int i = 0; i < 10; i++) tick();
      TIMERINT = 2'b00;
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("held_rawpend", rd, 32'h2);
      check("held_irq", {31'd0, IRQ}, 32'd0);
      apb_xfer(1'b0, 12'h014, 32'h0, rd, er);
      check("held_count1", rd, CNT_ON ? 32'd1 : 32'd0);
      apb_xfer(1'b1, 12'h004, 32'h2, rd, er);
      check("en_irq_lag", {31'd0, IRQ}, 32'd0);
      tick();
      check("en_irq_rise", {31'd0, IRQ}, 32'd1);

      // erroring accesses change nothing
      apb_xfer(1'b0, 12'h018, 32'h0, rd, er);
      check("oob_err", {31'd0, er}, 32'd1);
      check("oob_rdata", rd, 32'h0);
      apb_xfer(1'b1, 12'h000, 32'h0, rd, er);
      check("ro_wr_err", {31'd0, er}, 32'd1);
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("ro_wr_rawpend", rd, 32'h2);

      // reset in the middle of an ENABLE write with both pending
      TIMERINT = 2'b11;
      tick();
      TIMERINT = 2'b00;
      tick(); tick();
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("pre_rst_rawpend", rd, 32'h3);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 10'd1; bus.PWDATA = 32'h1;
      tick();
      bus.PENABLE = 1'b1; PRESET = 1'b1; TIMERINT = 2'b11;
      tick();
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      PRESET = 1'b0; TIMERINT = 2'b00; idle();
      tick();
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("rst_rawpend", rd, 32'h0);
      apb_xfer(1'b0, 12'h004, 32'h0, rd, er);
      check("rst_enable", rd, 32'h0);
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("rst_count0", rd, 32'h0);

      // level already high when reset releases counts as an edge
      PRESET = 1'b1; TIMERINT = 2'b01;
      tick(); tick();
      PRESET = 1'b0;
      tick();
      TIMERINT = 2'b00;
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("rel_rawpend", rd, 32'h1);

      // counters
      do_reset();
`ifdef TIMER_IRQ_AGG_COUNT_EN
      for (int i = 0; i < 70000; i++) begin
         TIMERINT = 2'b01; tick();
         TIMERINT = 2'b00; tick();
      end
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("sat_count0", rd, 32'h0000_FFFF);
      apb_xfer(1'b0, 12'h014, 32'h0, rd, er);
      check("sat_count1", rd, 32'h0);
      apb_xfer(1'b1, 12'h008, 32'h100, rd, er);
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("cnt_clear", rd, 32'h0);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 10'd2; bus.PWDATA = 32'h100;
      tick();
      bus.PENABLE = 1'b1; TIMERINT = 2'b01;
      tick();
      idle(); TIMERINT = 2'b00;
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("cnt_clear_race", rd, 32'h1);
`else
      for (int i = 0; i < 5; i++) begin
         TIMERINT = 2'b01; tick();
         TIMERINT = 2'b00; tick();
      end
      apb_xfer(1'b0, 12'h010, 32'h0, rd, er);
      check("nocnt_count0", rd, 32'h0);
      check("nocnt_err", {31'd0, er}, 32'd0);
      apb_xfer(1'b1, 12'h008, 32'h300, rd, er);
      apb_xfer(1'b0, 12'h000, 32'h0, rd, er);
      check("nocnt_clear_pend", rd, 32'h1);
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         PRESET      = ($urandom_range(0, 199) == 0);
         TIMERINT    = 2'($urandom);
         bus.PSEL    = ($urandom_range(0, 3) != 0);
         bus.PENABLE = ($urandom_range(0, 2) != 0);
         bus.PWRITE  = 1'($urandom);
         bus.PADDR   = ($urandom_range(0, 15) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
         bus.PWDATA  = $urandom;
         tick();
      end
      PRESET = 1'b0; idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
